// File: rtl/aoc_types_pkg.sv
// aoc_types_pkg: shared connection types, widths and top-k sorter state encoding
package aoc_types_pkg;
  localparam int NUM_POINTS = 1000;
  localparam int PT_W = $clog2(NUM_POINTS);
  localparam int DIST_W = 40;
  typedef struct packed {
    logic [DIST_W-1:0] distance;
    logic [PT_W-1:0]   pointa;
    logic [PT_W-1:0]   pointb;
  } conn_t;
  typedef struct packed {
    logic  vld;
    conn_t conn;
  } topk_entry_t;
  typedef enum logic [1:0] {COLLECT, FLUSH, DRAIN, DONE} topk_state_t;
endpackage

// File: rtl/topk_cell.sv
// topk_cell: one slot of the ascending insertion-sort array
// Ports: clk, rst_n (async active-low); i_conn new connection; i_left/i_left_lt
// left neighbour entry and its compare; i_right right neighbour entry;
// i_ins insert strobe; i_pop shift-up strobe; o_e held entry; o_lt new goes here or earlier.
module topk_cell
  import aoc_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  conn_t       i_conn,
  input  topk_entry_t i_left,
  input  logic        i_left_lt,
  input  topk_entry_t i_right,
  input  logic        i_ins,
  input  logic        i_pop,
  output topk_entry_t o_e,
  output logic        o_lt
);
  topk_entry_t r_e;
  assign o_e = r_e;
  // strict compare places a new equal-distance entry after existing equals
  assign o_lt = !r_e.vld || i_conn.distance < r_e.conn.distance;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_e <= '0;
    else if (i_ins && o_lt) r_e <= i_left_lt ? i_left : '{vld: 1'b1, conn: i_conn};
    else if (i_pop) r_e <= i_right;
endmodule

// File: rtl/conn_topk_sorter.sv
// conn_topk_sorter: keeps the K_SEL shortest connections sorted, then drains them ascending
// Ports: clk, rst_n (async active-low); in_conn/in_vld/in_done upstream stream (no backpressure);
// out_conn/out_vld/out_rdy/out_last drained stream; count entries held;
// sorted_done drain finished; drop_err input arrived after collection closed.
module conn_topk_sorter
  import aoc_types_pkg::*;
#(
  parameter int K_SEL = 1000,
  parameter int FLUSH_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  conn_t                      in_conn,
  input  logic                       in_vld,
  input  logic                       in_done,
  output conn_t                      out_conn,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic                       out_last,
  output logic [$clog2(K_SEL+1)-1:0] count,
  output logic                       sorted_done,
  output logic                       drop_err
);
  localparam int CW = $clog2(K_SEL + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  topk_state_t r_state, w_next;
  logic [FW-1:0] r_flush;
  logic [CW-1:0] r_count;
  logic r_drop;
  topk_entry_t w_e [K_SEL+1];
  logic [K_SEL-1:0] w_lt;
  logic w_ins, w_pop, w_full;
  assign w_e[K_SEL] = '0;
  assign w_ins = in_vld && (r_state == COLLECT || r_state == FLUSH);
  assign w_pop = out_vld && out_rdy;
  assign w_full = r_count == CW'(K_SEL);
  for (genvar i = 0; i < K_SEL; i++) begin : g_cell
    topk_entry_t w_left;
    logic w_left_lt;
    if (i == 0) begin : g_head
      assign w_left = '0;
      assign w_left_lt = 1'b0;
    end else begin : g_tail
      assign w_left = w_e[i-1];
      assign w_left_lt = w_lt[i-1];
    end
    topk_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_conn   (in_conn),
      .i_left   (w_left),
      .i_left_lt(w_left_lt),
      .i_right  (w_e[i+1]),
      .i_ins    (w_ins),
      .i_pop    (w_pop),
      .o_e      (w_e[i]),
      .o_lt     (w_lt[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= COLLECT;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == COLLECT && in_done)    ? FLUSH :
             (r_state == FLUSH && r_flush == '0) ? DRAIN :
             (r_state == DRAIN && r_count == '0) ? DONE  : r_state;
  always_comb begin
    out_vld = r_state == DRAIN && r_count != '0;
    out_last = out_vld && r_count == CW'(1);
    out_conn = w_e[0].conn;
    sorted_done = r_state == DONE;
    drop_err = r_drop;
    count = r_count;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_flush <= '0;
    else if (r_state == COLLECT && in_done) r_flush <= FW'(FLUSH_CYC - 1);
    else if (r_state == FLUSH && r_flush != '0) r_flush <= r_flush - FW'(1);
  // w_lt of the last slot is true exactly when the new entry will be retained
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (w_ins && w_lt[K_SEL-1] && !w_full) r_count <= r_count + CW'(1);
    else if (w_pop) r_count <= r_count - CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_drop <= 1'b0;
    else if (in_vld && (r_state == DRAIN || r_state == DONE)) r_drop <= 1'b1;
endmodule

// File: tb/tb_conn_topk_sorter.sv
// tb_conn_topk_sorter: queue-model checked bench for conn_topk_sorter with K_SEL=4, FLUSH_CYC=4
module tb_conn_topk_sorter;
  import aoc_types_pkg::*;
  localparam int K = 4;
  localparam int F = 4;
  logic clk = 0, rst_n = 1;
  conn_t in_conn = '0;
  logic in_vld = 0, in_done = 0, out_rdy = 0;
  conn_t out_conn;
  logic out_vld, out_last, sorted_done, drop_err;
  logic [2:0] count;
  int checks = 0, failures = 0;
  bit chk_en = 0;
  conn_t mq[$];
  int ph, fl, msz, mpos;
  bit mdrop, m_ev;
  conn_t seen[$];
  bit seen_last[$];
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  always #5 clk = ~clk;
  conn_topk_sorter #(.K_SEL(K), .FLUSH_CYC(F)) dut (
    .clk(clk), .rst_n(rst_n), .in_conn(in_conn), .in_vld(in_vld), .in_done(in_done),
    .out_conn(out_conn), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .count(count), .sorted_done(sorted_done), .drop_err(drop_err)
  );
  function automatic conn_t mk(int d, int a, int b);
    return '{distance: DIST_W'(d), pointa: PT_W'(a), pointb: PT_W'(b)};
  endfunction
  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask
  // model: sorted queue truncated to K, plus phase bookkeeping
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      ph = 0;
      fl = 0;
      mdrop = 0;
    end else begin
      msz = mq.size();
      if (in_vld && ph >= 2) mdrop = 1;
      if (in_vld && ph < 2) begin
        mpos = mq.size();
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].distance > in_conn.distance) mpos = i;
        mq.insert(mpos, in_conn);
        if (mq.size() > K) void'(mq.pop_back());
      end
      if (ph == 2 && msz > 0 && out_rdy) void'(mq.pop_front());
      case (ph)
        0: if (in_done) begin ph = 1; fl = F - 1; end
        1: if (fl == 0) ph = 2; else fl--;
        2: if (msz == 0) ph = 3;
        default: ;
      endcase
    end
  end
  always @(negedge clk) if (chk_en) begin
    m_ev = ph == 2 && mq.size() != 0;
    chk("out_vld", out_vld, m_ev);
    chk("out_conn", out_conn, mq.size() != 0 ? mq[0] : '0);
    chk("out_last", out_last, m_ev && mq.size() == 1);
    chk("count", count, mq.size());
    chk("sorted_done", sorted_done, ph == 3);
    chk("drop_err", drop_err, mdrop);
    if (out_vld && out_rdy) begin
      seen.push_back(out_conn);
      seen_last.push_back(out_last);
    end
  end
  task automatic step(bit v, int d, int a, int b, bit dn, bit rdy);
    @(posedge clk);
    #2;
    in_vld = v;
    in_conn = mk(d, a, b);
    in_done = dn;
    out_rdy = rdy;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    in_vld = 0;
    in_done = 0;
    rst_n = 0;
    @(posedge clk);
    #2;
    rst_n = 1;
    seen.delete();
    seen_last.delete();
  endtask
  task automatic run_drain(bit bp);
    int n = 0;
    while (!sorted_done && n < 60) begin
      step(0, 0, 0, 0, 0, bp ? pat[n%4] : 1'b1);
      n++;
    end
    if (!sorted_done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=0 exp=1");
    end
  endtask
  task automatic chk_zero(string n);
    chk({n, "_count"}, count, 0);
    chk({n, "_vld"}, out_vld, 0);
    chk({n, "_last"}, out_last, 0);
    chk({n, "_conn"}, out_conn, 0);
    chk({n, "_done"}, sorted_done, 0);
    chk({n, "_drop"}, drop_err, 0);
  endtask
  initial begin
    int n;
    int d1[4] = '{10, 20, 30, 40};
    #1 rst_n = 0;
    #1 chk_en = 1;
    chk_zero("reset");
    #10 rst_n = 1;
    // basic sort
    step(1, 50, 1, 2, 0, 1); step(1, 10, 3, 4, 0, 1); step(1, 40, 5, 6, 0, 1);
    step(1, 30, 7, 8, 0, 1); step(1, 20, 9, 10, 0, 1); step(0, 0, 0, 0, 1, 1);
    run_drain(0);
    chk("t1_n", seen.size(), 4);
    if (seen.size() == 4) for (int i = 0; i < 4; i++) chk("t1_dist", seen[i].distance, d1[i]);
    if (seen.size() == 4) begin
      chk("t1_last0", seen_last[0], 0);
      chk("t1_last3", seen_last[3], 1);
    end
    // ties keep arrival order, fifth equal dropped
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 7, 2*i+1, 2*i+2, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    run_drain(0);
    chk("t2_n", seen.size(), 4);
    if (seen.size() == 4) for (int i = 0; i < 4; i++) begin
      chk("t2_a", seen[i].pointa, 2*i+1);
      chk("t2_b", seen[i].pointb, 2*i+2);
    end
    // late arrival in the third flush cycle
    do_reset();
    step(1, 20, 1, 1, 0, 1); step(1, 30, 2, 2, 0, 1); step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 1); step(1, 5, 3, 3, 0, 1);
    run_drain(0);
    chk("t3_n", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("t3_first", seen[0].distance, 5);
      chk("t3_second", seen[1].distance, 20);
    end
    // backpressure
    do_reset();
    step(1, 4, 1, 1, 0, 0); step(1, 3, 2, 2, 0, 0); step(1, 2, 3, 3, 0, 0);
    step(1, 1, 4, 4, 0, 0); step(0, 0, 0, 0, 1, 0);
    run_drain(1);
    chk("t4_n", seen.size(), 4);
    if (seen.size() == 4) for (int i = 0; i < 4; i++) chk("t4_dist", seen[i].distance, i + 1);
    // empty run then drop_err
    do_reset();
    step(0, 0, 0, 0, 1, 1);
    n = 0;
    while (!sorted_done && n < 20) begin @(negedge clk); n++; end
    chk("t5_done_cycles", n, 7);
    chk("t5_count", count, 0);
    chk("t5_n", seen.size(), 0);
    step(1, 99, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t5_drop", drop_err, 1);
    // async reset mid-drain
    do_reset();
    step(1, 9, 1, 1, 0, 1); step(1, 8, 2, 2, 0, 1); step(1, 7, 3, 3, 0, 1);
    step(1, 6, 4, 4, 0, 1); step(0, 0, 0, 0, 1, 1);
    n = 0;
    while (seen.size() < 2 && n < 30) begin step(0, 0, 0, 0, 0, 1); n++; end
    chk("t6_pops", seen.size(), 2);
    rst_n = 0;
    #1 chk_zero("t6_async");
    @(posedge clk);
    #2 rst_n = 1;
    seen.delete();
    seen_last.delete();
    step(1, 3, 1, 1, 0, 1); step(1, 1, 2, 2, 0, 1); step(0, 0, 0, 0, 1, 1);
    run_drain(0);
    chk("t6_n", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("t6_first", seen[0].distance, 1);
      chk("t6_second", seen[1].distance, 3);
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
